// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM access arbiter.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Width of a port index; never narrower than one bit.
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester/core bus seen by the arbiter. master = requesters plus core, slave = arbiter.
interface sdram_arbiter_if
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS = 3
);
  localparam int IDX_W = port_idx_w(NUM_PORTS);

  // requester side
  logic [NUM_PORTS*SDRAM_ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]              req_read;
  logic [NUM_PORTS-1:0]              req_write;
  logic [NUM_PORTS*SDRAM_DATA_W-1:0] req_writedata;
  logic [SDRAM_DATA_W-1:0]           req_readdata;
  logic [NUM_PORTS-1:0]              req_finished;

  // core side
  logic [SDRAM_ADDR_W-1:0]           sdram_addr;
  logic                              sdram_read;
  logic                              sdram_write;
  logic [SDRAM_DATA_W-1:0]           sdram_writedata;
  logic [SDRAM_DATA_W-1:0]           sdram_readdata;
  logic                              sdram_finished;

  // status
  logic [IDX_W-1:0]                  grant_id;
  logic                              o_busy;
  logic                              o_timeout;

  modport master (
    output req_addr, req_read, req_write, req_writedata,
    output sdram_readdata, sdram_finished,
    input  req_readdata, req_finished,
    input  sdram_addr, sdram_read, sdram_write, sdram_writedata,
    input  grant_id, o_busy, o_timeout
  );

  modport slave (
    input  req_addr, req_read, req_write, req_writedata,
    input  sdram_readdata, sdram_finished,
    output req_readdata, req_finished,
    output sdram_addr, sdram_read, sdram_write, sdram_writedata,
    output grant_id, o_busy, o_timeout
  );

endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first requester at or after (ptr+1), wrapping.
module sdram_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  // cand[k] is the port at distance k+1 after the pointer; cand[NUM_PORTS-1] is the pointer itself
  logic [IDX_W-1:0] cand [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr_i} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_PORTS))
                        ? IDX_W'(sum - (IDX_W+1)'(NUM_PORTS))
                        : sum[IDX_W-1:0];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        valid_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM access core between NUM_PORTS requesters.
// One transaction per grant, a forced release cycle after each, and a watchdog abort.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sdram_arbiter_if.slave bus
);

  localparam int          IDX_W      = port_idx_w(NUM_PORTS);
  localparam logic [31:0] WDOG_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [31:0]             wdog_q, wdog_d;
  logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SDRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [SDRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]    fin_q, fin_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;

  // Per-port views of the flattened request buses.
  logic [NUM_PORTS-1:0]    port_req;
  logic [SDRAM_ADDR_W-1:0] port_addr  [NUM_PORTS];
  logic [SDRAM_DATA_W-1:0] port_wdata [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_req[gi]   = bus.req_read[gi] | bus.req_write[gi];
      assign port_addr[gi]  = bus.req_addr[gi*SDRAM_ADDR_W +: SDRAM_ADDR_W];
      assign port_wdata[gi] = bus.req_writedata[gi*SDRAM_DATA_W +: SDRAM_DATA_W];
    end
  endgenerate

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  sdram_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i   (port_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // In IDLE the candidate is the picker's choice; otherwise it is the current owner.
  logic [IDX_W-1:0] sel_idx;
  logic             sel_read, sel_write;
  assign sel_idx   = (state_q == ARB_IDLE) ? pick_idx : grant_q;
  assign sel_read  = bus.req_read[sel_idx];
  assign sel_write = bus.req_write[sel_idx];

  // Next-state and next-output logic for the grant/transaction/release cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    wdog_d    = wdog_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    fin_d     = '0;
    timeout_d = timeout_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = port_addr[sel_idx];
          wdata_d = port_wdata[sel_idx];
          wr_d    = sel_write;
          rd_d    = sel_read & ~sel_write;  // write wins when both are asserted
          wdog_d  = '0;
          state_d = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        addr_d  = port_addr[sel_idx];
        wdata_d = port_wdata[sel_idx];
        if (bus.sdram_finished) begin
          // completion has priority over a simultaneous watchdog expiry
          rd_d           = 1'b0;
          wr_d           = 1'b0;
          rdata_d        = bus.sdram_readdata;
          fin_d[grant_q] = 1'b1;
          ptr_d          = grant_q;
          state_d        = ARB_RELEASE;
        end else if (!(sel_read || sel_write)) begin
          // owner gave up: release silently
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ptr_d   = grant_q;
          state_d = ARB_RELEASE;
        end else if (wdog_q == WDOG_LIMIT) begin
          // hung core: complete the owner with zero data and flag it
          rd_d           = 1'b0;
          wr_d           = 1'b0;
          rdata_d        = '0;
          fin_d[grant_q] = 1'b1;
          timeout_d      = 1'b1;
          ptr_d          = grant_q;
          state_d        = ARB_RELEASE;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 32'd1;
        end
      end

      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers; reset drops strobes and pulses at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      wdog_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      fin_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wdog_q    <= wdog_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.sdram_addr      = addr_q;
  assign bus.sdram_writedata = wdata_q;
  assign bus.sdram_read      = rd_q;
  assign bus.sdram_write     = wr_q;
  assign bus.req_readdata    = rdata_q;
  assign bus.req_finished    = fin_q;
  assign bus.grant_id        = grant_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_timeout       = timeout_q;

endmodule
